// File: rtl/dram_arbiter_n.sv
// dram_arbiter_n: round-robin DRAM arbiter for NUM_CORES cores plus a priority external port.
// Optional feature macro ARB_STATS_EN adds a saturating stall_count output.
module dram_arbiter_n #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ext_en,
  input  logic                      ext_write,
  input  logic                      ext_read,
  input  logic [ADDR_W-1:0]         ext_addr,
  input  logic [DATA_W-1:0]         ext_wdata,
  output logic [DATA_W-1:0]         ext_rdata,
  output logic                      ext_rvalid,
  input  logic [NUM_CORES-1:0]      core_req,
  input  logic [NUM_CORES-1:0]      core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]      core_gnt,
  output logic [DATA_W-1:0]         core_rdata,
  output logic [NUM_CORES-1:0]      core_rvalid,
  output logic [ADDR_W-1:0]         dram_addr,
  output logic [DATA_W-1:0]         dram_wdata,
  output logic                      dram_write_en,
  output logic                      dram_read_en,
  input  logic [DATA_W-1:0]         dram_rdata,
  output logic                      busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic                 src_ext_q, src_ext_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    dram_addr_q, dram_addr_d;
  logic [DATA_W-1:0]    dram_wdata_q, dram_wdata_d;
  logic                 dram_write_en_q, dram_write_en_d;
  logic                 dram_read_en_q, dram_read_en_d;
  logic [NUM_CORES-1:0] core_gnt_q, core_gnt_d;
  logic [CNT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]    ext_rdata_q, ext_rdata_d;
  logic [NUM_CORES-1:0] core_rvalid_q, core_rvalid_d;
  logic                 ext_rvalid_q, ext_rvalid_d;

  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx;
  int                   cand;

  // Round-robin search starting one past the most recently granted core.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = int'(last_gnt_q) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!rr_found && core_req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    last_gnt_d      = last_gnt_q;
    src_d           = src_q;
    src_ext_d       = src_ext_q;
    we_d            = we_q;
    dram_addr_d     = dram_addr_q;
    dram_wdata_d    = dram_wdata_q;
    dram_write_en_d = 1'b0;
    dram_read_en_d  = 1'b0;
    core_gnt_d      = '0;
    lat_cnt_d       = lat_cnt_q;
    core_rdata_d    = core_rdata_q;
    ext_rdata_d     = ext_rdata_q;
    core_rvalid_d   = '0;
    ext_rvalid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ext_en && (ext_write || ext_read)) begin
          src_ext_d       = 1'b1;
          we_d            = ext_write;
          dram_addr_d     = ext_addr;
          dram_wdata_d    = ext_wdata;
          dram_write_en_d = ext_write;
          dram_read_en_d  = !ext_write;
          state_d         = CMD;
        end else if (!ext_en && rr_found) begin
          src_ext_d          = 1'b0;
          src_d              = rr_idx;
          we_d               = core_we[rr_idx];
          dram_addr_d        = core_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
          dram_wdata_d       = core_wdata[int'(rr_idx)*DATA_W +: DATA_W];
          dram_write_en_d    = core_we[rr_idx];
          dram_read_en_d     = !core_we[rr_idx];
          core_gnt_d[rr_idx] = 1'b1;
          state_d            = CMD;
        end
      end
      CMD: begin
        if (!src_ext_q) last_gnt_d = src_q;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = CNT_W'(READ_LAT - 1);
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == '0) begin
          if (src_ext_q) begin
            ext_rdata_d  = dram_rdata;
            ext_rvalid_d = 1'b1;
          end else begin
            core_rdata_d         = dram_rdata;
            core_rvalid_d[src_q] = 1'b1;
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      last_gnt_q      <= IDX_W'(NUM_CORES - 1);
      src_q           <= '0;
      src_ext_q       <= 1'b0;
      we_q            <= 1'b0;
      dram_addr_q     <= '0;
      dram_wdata_q    <= '0;
      dram_write_en_q <= 1'b0;
      dram_read_en_q  <= 1'b0;
      core_gnt_q      <= '0;
      lat_cnt_q       <= '0;
      core_rdata_q    <= '0;
      ext_rdata_q     <= '0;
      core_rvalid_q   <= '0;
      ext_rvalid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_gnt_q      <= last_gnt_d;
      src_q           <= src_d;
      src_ext_q       <= src_ext_d;
      we_q            <= we_d;
      dram_addr_q     <= dram_addr_d;
      dram_wdata_q    <= dram_wdata_d;
      dram_write_en_q <= dram_write_en_d;
      dram_read_en_q  <= dram_read_en_d;
      core_gnt_q      <= core_gnt_d;
      lat_cnt_q       <= lat_cnt_d;
      core_rdata_q    <= core_rdata_d;
      ext_rdata_q     <= ext_rdata_d;
      core_rvalid_q   <= core_rvalid_d;
      ext_rvalid_q    <= ext_rvalid_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles where some core waits and nobody is being granted; sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if ((|core_req) && !(|core_gnt_q) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

  assign ext_rdata     = ext_rdata_q;
  assign ext_rvalid    = ext_rvalid_q;
  assign core_gnt      = core_gnt_q;
  assign core_rdata    = core_rdata_q;
  assign core_rvalid   = core_rvalid_q;
  assign dram_addr     = dram_addr_q;
  assign dram_wdata    = dram_wdata_q;
  assign dram_write_en = dram_write_en_q;
  assign dram_read_en  = dram_read_en_q;
  assign busy          = (state_q != IDLE);

endmodule
